sobel_processing_unit_uc: RTL and testbench

- Control unit (FSM) that sequences sobel_processing_unit_fd through one frame per start command: clear, receive raw frame, run the Sobel kernel, transmit the result pixel by pixel.
- Drives the datapath strobes (calcula, tx_enable, tx_pronto) and the external UART transmitter start.
- Watchdogs each phase and reports done/error to the top level.

---
 rtl/sobel_processing_unit_uc.sv | 128 ++++++++++++
 tb/tb_sobel_processing_unit_uc.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_processing_unit_uc.sv
// rtl/sobel_processing_unit_uc.sv - Control FSM sequencing the Sobel datapath through one frame
// Clear, receive, convolve, transmit; every waiting phase is guarded by a shared watchdog.
module sobel_processing_unit_uc #(
   parameter int WIDTH   = 160,
   parameter int HEIGHT  = 120,
   parameter int TIMEOUT = 50000000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       rx_pronto,
   input  logic       tx_fim,
   input  logic       fim_imagem,
   output logic       limpa_fd,
   output logic       calcula,
   output logic       tx_enable,
   output logic       tx_pronto,
   output logic       tx_partida,
   output logic       pronto,
   output logic       erro,
   output logic [3:0] db_estado
);

   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

   // The frame geometry lives in the datapath; a degenerate frame has no last pixel.
   if (WIDTH * HEIGHT < 1) begin : g_invalid_geometry
   end

   typedef enum logic [3:0] {
      OCIOSO       = 4'd0,
      LIMPA        = 4'd1,
      RECEBE       = 4'd2,
      CALCULA      = 4'd3,
      TRANSMITE    = 4'd4,
      ESPERA_ENVIO = 4'd5,
      AVANCA       = 4'd6,
      FIM          = 4'd7,
      ERRO         = 4'd8
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [WD_W-1:0] r_wd;
   logic            r_rx_iniciado;
   logic            r_fim_ant;
   logic            w_wd_exp;
   logic            w_wd_clr;
   logic            w_wd_inc;
   logic            w_state_chg;

   assign w_wd_exp    = (r_wd == WD_MAX);
   assign w_state_chg = (w_next != r_state);
   assign db_estado   = r_state;

   // Terminating events are tested before expiry so an event on the expiry cycle wins.
   always_comb begin
      w_next   = r_state;
      w_wd_clr = 1'b0;
      w_wd_inc = 1'b0;
      case (r_state)
         OCIOSO, FIM, ERRO: begin
            if (iniciar) w_next = LIMPA;
         end
         LIMPA: w_next = RECEBE;
         RECEBE: begin
            if (rx_pronto) begin
               w_wd_clr = 1'b1;
               if (fim_imagem) w_next = CALCULA;
            end else if (r_rx_iniciado) begin
               if (w_wd_exp) w_next = ERRO;
               else          w_wd_inc = 1'b1;
            end
         end
         CALCULA: begin
            if (r_fim_ant && !fim_imagem) w_next = TRANSMITE;
            else if (w_wd_exp)            w_next = ERRO;
            else                          w_wd_inc = 1'b1;
         end
         TRANSMITE: w_next = ESPERA_ENVIO;
         ESPERA_ENVIO: begin
            if (tx_fim)        w_next = AVANCA;
            else if (w_wd_exp) w_next = ERRO;
            else               w_wd_inc = 1'b1;
         end
         AVANCA: w_next = fim_imagem ? FIM : TRANSMITE;
         default: w_next = OCIOSO;
      endcase
   end

   // Outputs are decoded from the next state so they are registered yet aligned with the state.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state       <= OCIOSO;
         r_wd          <= '0;
         r_rx_iniciado <= 1'b0;
         r_fim_ant     <= 1'b0;
         limpa_fd      <= 1'b0;
         calcula       <= 1'b0;
         tx_enable     <= 1'b0;
         tx_pronto     <= 1'b0;
         tx_partida    <= 1'b0;
         pronto        <= 1'b0;
         erro          <= 1'b0;
      end else begin
         r_state <= w_next;

         if (w_state_chg || w_wd_clr) r_wd <= '0;
         else if (w_wd_inc)           r_wd <= r_wd + WD_W'(1);

         if (w_state_chg)                        r_rx_iniciado <= 1'b0;
         else if (r_state == RECEBE && rx_pronto) r_rx_iniciado <= 1'b1;

         if (w_state_chg) r_fim_ant <= 1'b0;
         else             r_fim_ant <= fim_imagem;

         limpa_fd   <= (w_next == LIMPA);
         calcula    <= (w_next == CALCULA);
         tx_enable  <= (w_next == TRANSMITE) || (w_next == ESPERA_ENVIO) || (w_next == AVANCA);
         tx_pronto  <= (w_next == AVANCA);
         tx_partida <= (w_next == TRANSMITE);
         pronto     <= (w_next == FIM);
         erro       <= (w_next == ERRO);
      end
   end

endmodule

// File: tb/tb_sobel_processing_unit_uc.sv
// tb/tb_sobel_processing_unit_uc.sv - Randomized self-checking bench for the Sobel control FSM
// A frame-level datapath and UART model drive fim_imagem/tx_fim; timing rules are checked arithmetically.
module tb_sobel_processing_unit_uc;

   localparam int W  = 4;
   localparam int H  = 2;
   localparam int TO = 20;
   localparam int N  = W * H;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       iniciar = 1'b0;
   logic       rx_pronto = 1'b0;
   logic       tx_fim;
   logic       fim_imagem;
   logic       limpa_fd, calcula, tx_enable, tx_pronto, tx_partida, pronto, erro;
   logic [3:0] db_estado;
   logic       uart_en = 1'b1;

   always #5 clock = ~clock;

   sobel_processing_unit_uc #(.WIDTH(W), .HEIGHT(H), .TIMEOUT(TO)) dut (
      .clock(clock), .reset(reset), .iniciar(iniciar), .rx_pronto(rx_pronto),
      .tx_fim(tx_fim), .fim_imagem(fim_imagem), .limpa_fd(limpa_fd), .calcula(calcula),
      .tx_enable(tx_enable), .tx_pronto(tx_pronto), .tx_partida(tx_partida),
      .pronto(pronto), .erro(erro), .db_estado(db_estado)
   );

   wire [6:0] w_strobes = {limpa_fd, calcula, tx_enable, tx_pronto, tx_partida, pronto, erro};

   // Output snapshot taken mid-cycle, consumed by the models at the following edge.
   logic s_limpa = 1'b0, s_calc = 1'b0, s_txen = 1'b0, s_txpr = 1'b0, s_part = 1'b0;
   always @(negedge clock) begin
      s_limpa <= limpa_fd;
      s_calc  <= calcula;
      s_txen  <= tx_enable;
      s_txpr  <= tx_pronto;
      s_part  <= tx_partida;
   end

   int raw = 0, sob = 0, txa = 0, ucnt = 0;
   int n_part = 0, n_pron = 0, last_str = 0;
   int order_err = 0, alt_err = 0, inv_err = 0;

   assign fim_imagem = ((tx_enable ? txa : (calcula ? sob : raw)) == N - 1);
   assign tx_fim     = uart_en && (ucnt == 1);

   always @(posedge clock) begin
      if (s_limpa) begin
         raw <= 0; sob <= 0; txa <= 0;
         n_part <= 0; n_pron <= 0; last_str <= 0;
      end else begin
         if (rx_pronto) raw <= (raw == N - 1) ? 0 : raw + 1;
         if (s_calc)    sob <= (sob == N - 1) ? 0 : sob + 1;
         if (s_txpr)    txa <= (txa == N - 1) ? 0 : txa + 1;
         if (s_part) begin
            if (txa != n_part) order_err <= order_err + 1;
            if (last_str == 1) alt_err <= alt_err + 1;
            last_str <= 1;
            n_part   <= n_part + 1;
         end
         if (s_txpr) begin
            if (last_str != 1) alt_err <= alt_err + 1;
            last_str <= 2;
            n_pron   <= n_pron + 1;
         end
      end
      if ((s_calc && s_txen) || (s_part && s_txpr)) inv_err <= inv_err + 1;
      if (s_part && uart_en) ucnt <= int'($urandom_range(1, 12));
      else if (ucnt != 0)    ucnt <= ucnt - 1;
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic start_frame(input string tag);
      iniciar = 1'b1;
      tick();
      check({tag, "_limpa_state"}, 32'(db_estado), 1);
      check({tag, "_limpa_strobes"}, 32'(w_strobes), 32'h40);
      iniciar = 1'b0;
      tick();
      check({tag, "_recebe_state"}, 32'(db_estado), 2);
      check({tag, "_recebe_strobes"}, 32'(w_strobes), 0);
   endtask

   task automatic send_bytes(input int n, input int max_gap);
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, max_gap)) tick();
         rx_pronto = 1'b1;
         tick();
         rx_pronto = 1'b0;
      end
   endtask

   task automatic cycles_to_erro(output int k);
      k = 0;
      do begin
         tick();
         k++;
      end while (!erro && k < 100);
   endtask

   task automatic wait_state(input logic [3:0] s, output bit ok);
      int k = 0;
      while (db_estado != s && k < 200) begin
         tick();
         k++;
      end
      ok = (db_estado == s);
   endtask

   task automatic run_frame(input string tag, input bit poke_iniciar);
      int cnt;
      int k;
      start_frame(tag);
      if (poke_iniciar) begin
         send_bytes(3, 5);
         iniciar = 1'b1;
         tick();
         iniciar = 1'b0;
         check({tag, "_iniciar_ignored"}, 32'(db_estado), 2);
         send_bytes(N - 3, 5);
      end else begin
         send_bytes(N, 5);
      end
      check({tag, "_calcula_state"}, 32'(db_estado), 3);
      check({tag, "_calcula_level"}, 32'(calcula), 1);
      cnt = 1;
      while (calcula && cnt < 100) begin
         tick();
         if (calcula) cnt++;
      end
      check({tag, "_calcula_cycles"}, cnt, N + 1);
      check({tag, "_transmite_state"}, 32'(db_estado), 4);
      check({tag, "_first_partida"}, 32'(tx_partida), 1);
      k = 0;
      while (!pronto && k < 3000) begin
         tick();
         k++;
      end
      check({tag, "_pronto_reached"}, 32'(pronto), 1);
      check({tag, "_partida_count"}, n_part, N);
      check({tag, "_tx_pronto_count"}, n_pron, N);
      repeat (5) tick();
      check({tag, "_pronto_held"}, 32'({pronto, db_estado}), 32'h17);
   endtask

   initial begin
      int k;
      bit ok;

      repeat (3) tick();
      check("reset_outputs", 32'({w_strobes, db_estado}), 0);
      reset = 1'b1;
      tick();
      check("idle_state", 32'({w_strobes, db_estado}), 0);

      run_frame("f1", 1'b1);

      // Receive timeout: silence before the first byte is harmless, silence after it is not.
      start_frame("f2");
      repeat (30) tick();
      check("no_erro_before_first_byte", 32'({erro, db_estado}), 2);
      send_bytes(3, 5);
      cycles_to_erro(k);
      check("rx_timeout_cycles", k, TO + 1);
      check("rx_timeout_state", 32'(db_estado), 8);
      check("erro_strobes", 32'(w_strobes), 1);

      start_frame("f3");
      send_bytes(1, 0);
      repeat (TO) tick();
      rx_pronto = 1'b1;
      tick();
      rx_pronto = 1'b0;
      check("event_wins_state", 32'({erro, db_estado}), 2);
      cycles_to_erro(k);
      check("event_wins_wd_cleared", k, TO + 1);

      uart_en = 1'b0;
      start_frame("f4");
      send_bytes(N, 3);
      wait_state(4'd5, ok);
      check("espera_reached", 32'(ok), 1);
      cycles_to_erro(k);
      check("tx_timeout_cycles", k, TO + 1);
      check("tx_timeout_state", 32'(db_estado), 8);
      uart_en = 1'b1;

      start_frame("f5");
      send_bytes(N, 4);
      wait_state(4'd4, ok);
      check("transmite_reached", 32'(ok), 1);
      reset = 1'b0;
      #2;
      check("async_reset_outputs", 32'({w_strobes, db_estado}), 0);
      tick();
      reset = 1'b1;
      tick();
      check("after_reset_idle", 32'(db_estado), 0);

      run_frame("f6", 1'b0);

      check("pixel_order_errors", order_err, 0);
      check("strobe_alternation_errors", alt_err, 0);
      check("exclusive_strobe_errors", inv_err, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got %0d checks done, required completion", n_checks);
      $fatal(1, "bench time limit");
   end

endmodule
